armleocpu_mem_1rwm_arbiter: RTL and testbench
=============================================

Name: armleocpu_mem_1rwm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port, byte-enabled, read-first memory (armleocpu_mem_1rwm) between PORTS requesters.
- Each requester uses a valid/ready command channel and a valid/ready response channel.
- Every accepted command produces exactly one response.
- Sits between cache/TLB or peripheral clients and a shared storage array; the memory instance stays outside the block.

Parameters:
PORTS, 2, number of requesters (2..8)
ELEMENTS_W, 7, memory address width (2**ELEMENTS_W words)
WIDTH, 32, data width
GRANULITY, 8, bits per write-enable lane; WIDTH divisible by GRANULITY (ENABLE_WIDTH=WIDTH/GRANULITY)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
c_valid  in  PORTS  command valid per port
c_ready  out  PORTS  command accepted when c_valid[i]&c_ready[i]
c_write  in  PORTS  1=write, 0=read
c_address  in  PORTS*ELEMENTS_W  packed per-port address, port i at [i*ELEMENTS_W +: ELEMENTS_W]
c_writeenable  in  PORTS*ENABLE_WIDTH  packed per-port lane enables
c_writedata  in  PORTS*WIDTH  packed per-port write data
r_valid  out  PORTS  response valid, at most one bit set
r_ready  in  PORTS  response accept per port
r_readdata  out  WIDTH  read data, shared by all ports; meaningful only for read responses
m_address  out  ELEMENTS_W  to memory
m_read  out  1  to memory
m_write  out  1  to memory
m_writeenable  out  ENABLE_WIDTH  to memory
m_writedata  out  WIDTH  to memory
m_readdata  in  WIDTH  from memory; valid 1 cycle after m_read, held until the next read

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, r_valid=0, c_ready=0, m_read=0, m_write=0.
  - last_grant=PORTS-1, so port 0 has first priority.
  - An outstanding response is dropped; no memory access is issued during reset.
- State: IDLE (no outstanding response) or RESP (response pending for port owner, owner registered).
- can_issue = (state==IDLE) | (state==RESP & r_ready[owner]).
- Grant (combinational):
  - Scan c_valid starting at (last_grant+1) mod PORTS, wrapping; the first set bit wins.
  - c_ready = onehot(grant) & {PORTS{can_issue}}; at most one bit set.
- Issue: on an accepted command, in the same cycle:
  - m_address, m_writeenable and m_writedata come from the granted port.
  - m_read = ~c_write[g]; m_write = c_write[g].
  - Otherwise m_read=m_write=0; other m_* outputs are don't-care.
- Next edge after an issue: state=RESP, owner=g, last_grant=g.
- RESP:
  - r_valid[owner]=1; r_readdata=m_readdata, combinational pass-through.
  - The memory holds readdata because no new read is issued until the response is accepted.
  - On r_valid&r_ready with no new issue: IDLE.
  - On r_valid&r_ready with a same-cycle issue: stay RESP with the new owner. Back-to-back throughput is 1 command/cycle.
- Response stall: while r_ready[owner]=0, c_ready=0 for all ports and m_read=m_write=0.
- Write responses: r_valid pulses as an acknowledge; r_readdata is don't-care. A write does not disturb m_readdata.
- Latency: command accept to r_valid is exactly 1 cycle.
- Fairness: with all ports continuously valid, grants rotate 0,1,..,PORTS-1,0; no port waits more than PORTS-1 grants.
- Simultaneous c_valid and r_ready on the same port in RESP is legal; the new command may be accepted that cycle.
- c_valid with the port not granted: the command must be held stable by the requester (standard valid/ready).

Decomposition:
- Package armleocpu_mem_arb_pkg: state enum (IDLE, RESP), helper for the onehot width.
- Sub-module armleocpu_rr_arbiter: parameterized PORTS round-robin. Inputs req, last_grant, enable; outputs grant_onehot and grant_idx.
- Top: FSM, owner/last_grant registers, muxing.

Test Plan:
- Reset: hold rst_n=0 with c_valid=2'b11 -> c_ready=0, r_valid=0, m_read=m_write=0; release -> first grant port 0.
- Single read: write 0xDEADBEEF to addr 5 via port 0 (we=4'hF), then read addr 5 via port 1 -> r_valid=2'b10 one cycle after accept, r_readdata=0xDEADBEEF.
- Byte lanes: write 0x11223344 to addr 3, then write 0xAABBCCDD with we=4'b0101 -> read returns 0x11BB33DD.
- Round-robin: both ports continuously valid reading addrs 1/2, r_ready=1 -> grants alternate 0,1,0,1; one response per cycle, no bubbles.
- Backpressure: port 0 reads addr 5 (0xDEADBEEF) with r_ready=0 for 4 cycles while port 1 is valid -> c_ready=0, r_readdata stays 0xDEADBEEF; port 1 is granted in the same cycle r_ready[0] rises.
- Reset mid-operation: assert rst_n=0 while in RESP -> r_valid drops asynchronously; after release a new read of addr 5 returns the correct data.

Source files
------------

// File: rtl/armleocpu_mem_arb_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
// Pulled in by the arbiter top and its round-robin sub-module.
package armleocpu_mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_t;

  // Width needed to hold a port index; one bit minimum so a single-port build still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/armleocpu_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past last_grant and wraps.
// grant_idx is the winner even when enable is low; grant_onehot is gated by enable.
module armleocpu_rr_arbiter
  import armleocpu_mem_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int IDX_W = idx_width(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [PORTS-1:0] grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int   cand;
    logic found;
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    cand         = 0;
    for (int k = 1; k <= PORTS; k++) begin
      cand = (int'(last_grant) + k) % PORTS;
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    if (found && enable)
      grant_onehot[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/armleocpu_mem_1rwm_arbiter.sv
// Shares one single-port read-first memory between PORTS valid/ready requesters.
// One outstanding response at a time; a new command may issue in the cycle the response is taken.
//
// state | meaning
// IDLE  | no response outstanding, any valid command may issue
// RESP  | response for owner presented on r_valid, memory readdata held
module armleocpu_mem_1rwm_arbiter
  import armleocpu_mem_arb_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32,
  parameter int GRANULITY  = 8,
  localparam int ENABLE_WIDTH = WIDTH / GRANULITY
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [PORTS-1:0]              c_valid,
  output logic [PORTS-1:0]              c_ready,
  input  logic [PORTS-1:0]              c_write,
  input  logic [PORTS*ELEMENTS_W-1:0]   c_address,
  input  logic [PORTS*ENABLE_WIDTH-1:0] c_writeenable,
  input  logic [PORTS*WIDTH-1:0]        c_writedata,

  output logic [PORTS-1:0]              r_valid,
  input  logic [PORTS-1:0]              r_ready,
  output logic [WIDTH-1:0]              r_readdata,

  output logic [ELEMENTS_W-1:0]         m_address,
  output logic                          m_read,
  output logic                          m_write,
  output logic [ENABLE_WIDTH-1:0]       m_writeenable,
  output logic [WIDTH-1:0]              m_writedata,
  input  logic [WIDTH-1:0]              m_readdata
);

  localparam int IDX_W = idx_width(PORTS);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_grant;
  logic [PORTS-1:0] grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic             can_issue;
  logic             issue;

  // rst_n gates issue so nothing reaches the memory while reset is held.
  always_comb begin
    can_issue = rst_n & ((state == IDLE) | r_ready[owner]);
    issue     = can_issue & (|c_valid);
  end

  armleocpu_rr_arbiter #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req          (c_valid),
    .last_grant   (last_grant),
    .enable       (can_issue),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  always_comb begin
    c_ready       = grant_onehot;
    m_address     = c_address[int'(grant_idx)*ELEMENTS_W +: ELEMENTS_W];
    m_writeenable = c_writeenable[int'(grant_idx)*ENABLE_WIDTH +: ENABLE_WIDTH];
    m_writedata   = c_writedata[int'(grant_idx)*WIDTH +: WIDTH];
    m_read        = issue & ~c_write[grant_idx];
    m_write       = issue &  c_write[grant_idx];
  end

  // Memory keeps readdata stable until the next read, so the response path is a straight wire.
  always_comb begin
    r_valid    = '0;
    r_readdata = m_readdata;
    if (state == RESP)
      r_valid[owner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (issue)
      state_nxt = RESP;
    else if ((state == RESP) && r_ready[owner])
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(PORTS - 1);
    end else begin
      state <= state_nxt;
      if (issue) begin
        owner      <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_armleocpu_mem_1rwm_arbiter.sv
// Bench for the shared-memory arbiter: directed scenarios plus a randomized run,
// checked against a transaction-level model (pending response, last winner, shadow memory).
module tb_armleocpu_mem_1rwm_arbiter;

  localparam int P  = 2;
  localparam int AW = 7;
  localparam int W  = 32;
  localparam int G  = 8;
  localparam int EN = W / G;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [P-1:0]    c_valid, c_ready, c_write, r_valid, r_ready;
  logic [P*AW-1:0] c_address;
  logic [P*EN-1:0] c_writeenable;
  logic [P*W-1:0]  c_writedata;
  logic [W-1:0]    r_readdata, m_writedata, m_readdata;
  logic [AW-1:0]   m_address;
  logic            m_read, m_write;
  logic [EN-1:0]   m_writeenable;

  armleocpu_mem_1rwm_arbiter #(.PORTS(P), .ELEMENTS_W(AW), .WIDTH(W), .GRANULITY(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_valid(c_valid), .c_ready(c_ready), .c_write(c_write), .c_address(c_address),
    .c_writeenable(c_writeenable), .c_writedata(c_writedata),
    .r_valid(r_valid), .r_ready(r_ready), .r_readdata(r_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writeenable(m_writeenable), .m_writedata(m_writedata), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // External read-first single-port memory.
  logic [W-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (m_read) m_readdata <= mem[m_address];
    if (m_write)
      for (int l = 0; l < EN; l++)
        if (m_writeenable[l]) mem[m_address][8*l +: 8] <= m_writedata[8*l +: 8];
  end

  int checks = 0;
  int failures = 0;

  // Transaction model state.
  logic [W-1:0] ref_mem [0:(1<<AW)-1];
  int           ref_last;
  int           pend;
  logic         pend_read;
  logic [W-1:0] pend_data;
  int           exp_grant;
  logic         exp_can;
  logic [P-1:0] exp_cready, exp_rvalid;
  logic         exp_mread, exp_mwrite;

  task automatic model_reset();
    ref_last = P - 1;
    pend     = -1;
  endtask

  task automatic model_expect();
    exp_rvalid = '0;
    if (pend >= 0) exp_rvalid[pend] = 1'b1;
    exp_can   = (pend < 0) || r_ready[pend];
    exp_grant = -1;
    if (exp_can)
      for (int k = 1; k <= P; k++)
        if (exp_grant < 0 && c_valid[(ref_last + k) % P]) exp_grant = (ref_last + k) % P;
    exp_cready = '0;
    exp_mread  = 1'b0;
    exp_mwrite = 1'b0;
    if (exp_grant >= 0) begin
      exp_cready[exp_grant] = 1'b1;
      exp_mread  = !c_write[exp_grant];
      exp_mwrite =  c_write[exp_grant];
    end
  endtask

  task automatic model_commit();
    int a;
    if (exp_grant >= 0) begin
      a = int'(c_address[exp_grant*AW +: AW]);
      pend      = exp_grant;
      ref_last  = exp_grant;
      pend_read = !c_write[exp_grant];
      if (pend_read) pend_data = ref_mem[a];
      else
        for (int l = 0; l < EN; l++)
          if (c_writeenable[exp_grant*EN + l])
            ref_mem[a][8*l +: 8] = c_writedata[exp_grant*W + 8*l +: 8];
    end else if (exp_can && pend >= 0) begin
      pend = -1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_expect();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic set_cmd(input int p, input logic v, input logic wr, input int addr,
                         input logic [EN-1:0] we, input logic [W-1:0] data);
    c_valid[p]                = v;
    c_write[p]                = wr;
    c_address[p*AW +: AW]     = AW'(addr);
    c_writeenable[p*EN +: EN] = we;
    c_writedata[p*W +: W]     = data;
  endtask

  task automatic idle_cycles(input int n);
    c_valid = '0;
    r_ready = '1;
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_cmd(0, 1'b1, 1'b0, 0, '0, '0);
    set_cmd(1, 1'b1, 1'b0, 1, '0, '0);
    r_ready = '1;
    repeat (2) @(negedge clk);
    checks++; if (c_ready !== 2'b00) begin failures++; $display("FAIL reset_c_ready got=%b exp=00", c_ready); end
    checks++; if (r_valid !== 2'b00) begin failures++; $display("FAIL reset_r_valid got=%b exp=00", r_valid); end
    checks++; if ({m_read, m_write} !== 2'b00) begin failures++; $display("FAIL reset_mem_cmd got=%b exp=00", {m_read, m_write}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample();
    checks++; if (c_ready !== 2'b01) begin failures++; $display("FAIL reset_first_grant got=%b exp=01", c_ready); end
    advance();
    idle_cycles(2);
  endtask

  task automatic test_single_read();
    r_ready = '1;
    c_valid = '0;
    set_cmd(0, 1'b1, 1'b1, 5, 4'hF, 32'hDEADBEEF);
    sample();
    checks++; if (c_ready !== exp_cready || m_write !== 1'b1) begin failures++; $display("FAIL single_wr_issue c_ready=%b m_write=%b exp=%b/1", c_ready, m_write, exp_cready); end
    advance();
    c_valid = '0;
    set_cmd(1, 1'b1, 1'b0, 5, '0, '0);
    sample();
    checks++; if (r_valid !== 2'b01) begin failures++; $display("FAIL single_wr_ack got=%b exp=01", r_valid); end
    checks++; if (c_ready !== 2'b10 || m_read !== 1'b1) begin failures++; $display("FAIL single_rd_issue c_ready=%b m_read=%b exp=10/1", c_ready, m_read); end
    advance();
    c_valid = '0;
    sample();
    checks++; if (r_valid !== 2'b10) begin failures++; $display("FAIL single_rd_valid got=%b exp=10", r_valid); end
    checks++; if (r_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rd_data got=%h exp=deadbeef", r_readdata); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_byte_lanes();
    r_ready = '1;
    c_valid = '0;
    set_cmd(1, 1'b1, 1'b1, 3, 4'hF, 32'h11223344);
    sample(); advance();
    set_cmd(1, 1'b1, 1'b1, 3, 4'b0101, 32'hAABBCCDD);
    sample(); advance();
    set_cmd(1, 1'b1, 1'b0, 3, '0, '0);
    sample(); advance();
    c_valid = '0;
    sample();
    checks++; if (r_valid !== 2'b10 || r_readdata !== 32'h11BB33DD) begin failures++; $display("FAIL byte_lanes r_valid=%b data=%h exp=10/11bb33dd", r_valid, r_readdata); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_round_robin();
    logic [P-1:0] prev;
    r_ready = '1;
    set_cmd(0, 1'b1, 1'b0, 1, '0, '0);
    set_cmd(1, 1'b1, 1'b0, 2, '0, '0);
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      checks++; if (c_ready !== exp_cready) begin failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, c_ready, exp_cready); end
      if (i == 0) begin
        checks++; if (c_ready !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", c_ready); end
      end else begin
        checks++; if (c_ready === prev) begin failures++; $display("FAIL rr_alternate cyc=%0d got=%b prev=%b", i, c_ready, prev); end
        checks++; if (r_valid !== exp_rvalid || r_readdata !== pend_data) begin failures++; $display("FAIL rr_resp cyc=%0d r_valid=%b data=%h exp=%b/%h", i, r_valid, r_readdata, exp_rvalid, pend_data); end
      end
      prev = c_ready;
      advance();
    end
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    c_valid = '0;
    r_ready = 2'b00;
    set_cmd(0, 1'b1, 1'b0, 5, '0, '0);
    sample();
    checks++; if (c_ready !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", c_ready); end
    advance();
    c_valid = '0;
    set_cmd(1, 1'b1, 1'b0, 2, '0, '0);
    for (int i = 0; i < 4; i++) begin
      sample();
      checks++; if (c_ready !== 2'b00 || {m_read, m_write} !== 2'b00) begin failures++; $display("FAIL bp_stall cyc=%0d c_ready=%b mem=%b exp=00/00", i, c_ready, {m_read, m_write}); end
      checks++; if (r_valid !== 2'b01 || r_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_hold cyc=%0d r_valid=%b data=%h exp=01/deadbeef", i, r_valid, r_readdata); end
      advance();
    end
    r_ready = 2'b01;
    sample();
    checks++; if (c_ready !== 2'b10 || r_valid !== 2'b01) begin failures++; $display("FAIL bp_release c_ready=%b r_valid=%b exp=10/01", c_ready, r_valid); end
    advance();
    c_valid = '0;
    r_ready = '1;
    sample();
    checks++; if (r_valid !== 2'b10 || r_readdata !== pend_data) begin failures++; $display("FAIL bp_next r_valid=%b data=%h exp=10/%h", r_valid, r_readdata, pend_data); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_reset_mid();
    c_valid = '0;
    r_ready = 2'b00;
    set_cmd(0, 1'b1, 1'b0, 5, '0, '0);
    sample(); advance();
    c_valid = '0;
    sample();
    checks++; if (r_valid !== 2'b01) begin failures++; $display("FAIL mid_resp got=%b exp=01", r_valid); end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (r_valid !== 2'b00 || c_ready !== 2'b00) begin failures++; $display("FAIL mid_async_drop r_valid=%b c_ready=%b exp=00/00", r_valid, c_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_ready = '1;
    set_cmd(0, 1'b1, 1'b0, 5, '0, '0);
    sample();
    checks++; if (c_ready !== 2'b01) begin failures++; $display("FAIL mid_regrant got=%b exp=01", c_ready); end
    advance();
    c_valid = '0;
    sample();
    checks++; if (r_valid !== 2'b01 || r_readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_reread r_valid=%b data=%h exp=01/deadbeef", r_valid, r_readdata); end
    advance();
    idle_cycles(1);
  endtask

  task automatic test_random();
    logic [P-1:0] acc;
    acc = '0;
    c_valid = '0;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < P; p++)
        if (!c_valid[p] || acc[p])
          set_cmd(p, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 15)), EN'($urandom), W'($urandom));
      r_ready = P'($urandom) | P'($urandom);
      sample();
      checks++; if (c_ready !== exp_cready) begin failures++; $display("FAIL rand_c_ready cyc=%0d got=%b exp=%b", i, c_ready, exp_cready); end
      checks++; if (r_valid !== exp_rvalid) begin failures++; $display("FAIL rand_r_valid cyc=%0d got=%b exp=%b", i, r_valid, exp_rvalid); end
      checks++; if (m_read !== exp_mread || m_write !== exp_mwrite) begin failures++; $display("FAIL rand_mem_cmd cyc=%0d got=%b%b exp=%b%b", i, m_read, m_write, exp_mread, exp_mwrite); end
      if (pend >= 0 && pend_read) begin
        checks++; if (r_readdata !== pend_data) begin failures++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", i, r_readdata, pend_data); end
      end
      if (exp_grant >= 0) begin
        checks++; if (m_address !== c_address[exp_grant*AW +: AW]) begin failures++; $display("FAIL rand_m_address cyc=%0d got=%h exp=%h", i, m_address, c_address[exp_grant*AW +: AW]); end
      end
      acc = exp_cready;
      advance();
    end
    idle_cycles(2);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    c_valid = '0; c_write = '0; c_address = '0; c_writeenable = '0; c_writedata = '0;
    r_ready = '1;
    test_reset();
    test_single_read();
    test_byte_lanes();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
